fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the RV32I core. It generalises the fixed PC mux, PC increment and instruction-memory path into a decoupled stage.
- Keeps a PC and issues pipelined requests to a variable-latency instruction memory, up to MAX_OUTSTANDING in flight.
- Buffers returned words with their PCs in a FIFO_DEPTH-entry queue and hands them to decode over a valid/ready interface.
- Branch/jump redirects flush the queue and silently drop stale in-flight responses.

Parameters:
- PC_WIDTH, 32, width of all PCs and request addresses.
- INSTR_WIDTH, 32, instruction word width; PC step is INSTR_WIDTH/8 bytes.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction queue entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (1..FIFO_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  PC_WIDTH  fetch address (= fetch_pc).
- imem_rsp_valid  in  1  in-order response valid; always accepted.
- imem_rsp_data  in  INSTR_WIDTH  returned instruction word.
- redirect_valid  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  PC_WIDTH  new PC; the low log2(INSTR_WIDTH/8) bits are forced to zero.
- instr_valid  out  1  queue head valid to decode.
- instr_ready  in  1  decode consumes head.
- instr_data  out  INSTR_WIDTH  head instruction.
- instr_pc  out  PC_WIDTH  PC of head instruction.

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc = rsp_pc = RESET_PC.
  - outstanding = discard_cnt = 0; queue empty.
  - imem_req_valid = 0, instr_valid = 0, instr_data = 0, instr_pc = 0.
  - A reset mid-operation drops all in-flight responses; the memory is reset alongside.
- Issue:
  - imem_req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING && (outstanding + count) < FIFO_DEPTH.
  - The credit rule guarantees a queue slot for every response.
  - On req_valid && req_ready: fetch_pc += INSTR_WIDTH/8 (wraps modulo 2^PC_WIDTH) and outstanding increments.
- Request stability: imem_req_addr is held while valid and not ready. A redirect may withdraw an unaccepted request; the memory must tolerate this.
- Response handling:
  - If discard_cnt > 0, the word is dropped and discard_cnt decrements.
  - Otherwise {rsp_pc, data} is pushed into the queue and rsp_pc += step.
  - outstanding decrements in both cases. A simultaneous issue and response leaves it unchanged.
- Output: instr_valid = queue non-empty; data and PC come from the registered head. Pop on instr_valid && instr_ready.
- Redirect (priority over everything):
  - Queue cleared; fetch_pc = rsp_pc = redirect_pc; no request issued that cycle.
  - discard_cnt = outstanding, minus 1 if a response arrives that cycle. That response is itself dropped.
  - A handshake on the output in the same cycle completes (decode owns that word); the flush still happens.
- Latency:
  - Request accepted in cycle T, earliest response T+1, instr_valid earliest T+2.
  - After redirect in cycle R, the first new request is issued in R+1.
- Boundaries:
  - Queue full: issue stalls; no overflow is possible.
  - Queue empty with instr_ready high: no pop.
  - A response arriving with outstanding == 0 is illegal and caught by an assertion.
  - Back-to-back redirects: the last one wins. discard_cnt is reloaded each time from the current outstanding.

Optional Feature:
- FETCH_PERF_CNT_EN.
- When defined, adds output ports perf_fetched (32 bits, instructions popped to decode) and perf_discarded (32 bits, responses dropped after a redirect plus entries flushed from the queue).
- Both counters reset to 0, wrap on overflow and never saturate.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - INSTR_BYTES constant and the RV32I NOP constant 32'h0000_0013, used only by the bench.
  - typedef fetch_entry_t {pc, instr}.
- One sub-module, fetch_fifo: a synchronous FIFO of fetch_entry_t with push, pop, flush and count. Flush has priority over push.
- Counters and PC logic stay in fetch_unit.

Test Plan:
- Zero-wait memory, instr_ready=1 -> instr_pc 0x0,0x4,0x8,... one per cycle after two cycles of latency; outstanding never exceeds 2.
- instr_ready=0 for 20 cycles -> exactly 4 entries queued, imem_req_valid low; release -> PCs 0x0..0xC in order with no gaps.
- 3-cycle response latency, redirect to 0x100 with 2 requests outstanding -> both stale words dropped; next instr_pc is 0x100.
- Redirect coinciding with a response and with an output handshake -> handshake word delivered, response dropped, discard_cnt=1, then 0x100 stream.
- rst pulled low mid-burst -> outputs zero immediately; after release the first request address is RESET_PC.
- With FETCH_PERF_CNT_EN, run scenario 3 -> perf_discarded equals the dropped responses plus the flushed queue entries.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package fetch_pkg;
    localparam int PC_W        = 32;
    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = INSTR_W / 8;
    localparam logic [INSTR_W-1:0] RV32I_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue with push, pop, flush and occupancy count.
// Flush beats push; the head slot is a register so decode sees a clean output.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(fetch_entry_t)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [W-1:0]             o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A full queue may still take a push when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != FULL) || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Decoupled RV32I fetch stage: PC generation, credit-limited imem requests, response queue.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_discarded counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH        = 32,
    parameter int                  INSTR_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = 32'h0000_0000,
    parameter int                  FIFO_DEPTH      = 4,
    parameter int                  MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_discarded
`endif
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(INSTR_WIDTH / 8);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INSTR_WIDTH / 8 - 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] r_rsp_pc;
    logic [OW-1:0]       r_outstanding;
    logic [OW-1:0]       r_discard_cnt;
    logic [CW-1:0]       w_count;
    logic [PC_WIDTH-1:0] w_redirect_pc;
    logic                w_credit;
    logic                w_issue;
    logic                w_rsp_drop;
    logic                w_push;
    logic                w_pop;
    entry_t              w_push_entry;
    entry_t              w_head;

    // Every accepted request owns a queue slot, so responses can never overflow the queue.
    assign w_credit = (int'(r_outstanding) < MAX_OUTSTANDING) &&
                      (int'(r_outstanding) + int'(w_count) < FIFO_DEPTH);
    assign imem_req_valid = rst && !redirect_valid && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_issue        = imem_req_valid && imem_req_ready;

    assign w_rsp_drop = imem_rsp_valid && (redirect_valid || (r_discard_cnt != '0));
    assign w_push     = imem_rsp_valid && !w_rsp_drop;
    assign w_pop      = instr_valid && instr_ready;
    assign w_redirect_pc = redirect_pc & ALIGN_MASK;

    assign w_push_entry.pc    = r_rsp_pc;
    assign w_push_entry.instr = imem_rsp_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
        end else begin
            r_outstanding <= r_outstanding + OW'(w_issue) - OW'(imem_rsp_valid);
            if (redirect_valid) begin
                r_fetch_pc    <= w_redirect_pc;
                r_rsp_pc      <= w_redirect_pc;
                // Whatever is still in flight after this cycle belongs to the old path.
                r_discard_cnt <= r_outstanding - OW'(imem_rsp_valid);
            end else begin
                if (w_issue)    r_fetch_pc    <= r_fetch_pc + PC_STEP;
                if (w_push)     r_rsp_pc      <= r_rsp_pc + PC_STEP;
                if (w_rsp_drop) r_discard_cnt <= r_discard_cnt - OW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_valid (instr_valid),
        .o_count (w_count)
    );

    assign instr_data = w_head.instr;
    assign instr_pc   = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_discarded;
    logic [31:0] w_flushed;

    // A word handed to decode in the redirect cycle is delivered, not flushed.
    assign w_flushed = redirect_valid ? (32'(w_count) - 32'(w_pop)) : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetched   <= '0;
            r_perf_discarded <= '0;
        end else begin
            r_perf_fetched   <= r_perf_fetched + 32'(w_pop);
            r_perf_discarded <= r_perf_discarded + 32'(w_rsp_drop) + w_flushed;
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_discarded = r_perf_discarded;
`endif

    a_rsp_needs_req: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (r_outstanding != '0));
endmodule
